// File: rtl/game_pixel_compositor_if.sv
// Pixel-stream bundle between the game logic controller, the compositor and the TMDS encoder.
// The compositor uses the slave modport; the upstream/downstream side uses master.
interface game_pixel_compositor_if;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    logic [15:0] camera_pixel_in;
    logic        is_wall_in;
    logic        is_person_in;
    logic        is_collision_in;
    logic [7:0]  wall_depth_in;
    logic [7:0]  player_depth_in;
    logic [2:0]  game_state_in;

    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        data_valid_out;
    logic [23:0] pixel_out;
    logic [7:0]  player_depth_out;
    logic [19:0] collision_count_out;
    logic        frame_done_out;

    modport slave (
        input  hcount_in, vcount_in, data_valid_in, camera_pixel_in,
               is_wall_in, is_person_in, is_collision_in,
               wall_depth_in, player_depth_in, game_state_in,
        output hcount_out, vcount_out, data_valid_out, pixel_out,
               player_depth_out, collision_count_out, frame_done_out
    );

    modport master (
        output hcount_in, vcount_in, data_valid_in, camera_pixel_in,
               is_wall_in, is_person_in, is_collision_in,
               wall_depth_in, player_depth_in, game_state_in,
        input  hcount_out, vcount_out, data_valid_out, pixel_out,
               player_depth_out, collision_count_out, frame_done_out
    );
endinterface

// File: rtl/game_pixel_compositor.sv
// Two-stage pixel compositor: wall/person/collision mixing, game-over flash FSM and per-frame
// collision counting. Define GOAL_BAR_EN to add the wall-depth bar on the top eight rows.
module game_pixel_compositor #(
    parameter int SCREEN_WIDTH  = 1280,
    parameter int SCREEN_HEIGHT = 720,
    parameter int FLASH_FRAMES  = 60,
    parameter int FLASH_PERIOD  = 8,
    parameter int WALL_BASE     = 64
`ifdef GOAL_BAR_EN
    ,
    parameter int GOAL_DEPTH       = 60,
    parameter int GOAL_DEPTH_DELTA = 10
`endif
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    game_pixel_compositor_if.slave  bus
);

    localparam int              FC_W       = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FC_W-1:0] FLASH_LAST = FC_W'(FLASH_FRAMES - 1);
    localparam logic [19:0]     COUNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_FLASH,
        ST_OVER
    } state_e;

    typedef enum logic [1:0] {
        TINT_NONE,
        TINT_INVERT,
        TINT_OVER
    } tint_e;

    typedef struct packed {
        logic        valid;
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic        wall;
        logic        person;
        logic        collision;
        logic [7:0]  wall_depth;
        logic [7:0]  player_depth;
        logic [23:0] cam_rgb;
        tint_e       tint;
`ifdef GOAL_BAR_EN
        logic        bar;
        logic        goal_hit;
`endif
    } stage1_t;

    typedef struct packed {
        logic        valid;
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic [7:0]  player_depth;
        logic [23:0] pixel;
    } stage2_t;

    state_e          state_q, state_d;
    logic [FC_W-1:0] flash_count_q, flash_count_d;
    logic [19:0]     coll_acc_q, coll_acc_d;
    logic [19:0]     coll_count_q, coll_count_d;
    logic            frame_done_q, frame_done_d;
    stage1_t         s1_q, s1_d;
    stage2_t         s2_q, s2_d;

    logic            frame_end;
    logic            flash_phase;
    logic [19:0]     coll_total;

    // NOTE: every always_comb assigns all its outputs first so no path leaves a latch behind.
    always_comb begin
        frame_end = bus.data_valid_in
                 && (bus.hcount_in == 11'(SCREEN_WIDTH - 1))
                 && (bus.vcount_in == 10'(SCREEN_HEIGHT - 1));
        flash_phase = |((flash_count_q / FC_W'(FLASH_PERIOD)) & FC_W'(1));

        state_d       = state_q;
        flash_count_d = flash_count_q;
        if (frame_end) begin
            case (state_q)
                ST_PLAY: begin
                    if (bus.game_state_in == 3'd0) begin
                        state_d       = ST_FLASH;
                        flash_count_d = '0;
                    end
                end
                ST_FLASH: begin
                    if (bus.game_state_in != 3'd0) begin
                        state_d = ST_PLAY;
                    end else if (flash_count_q == FLASH_LAST) begin
                        state_d = ST_OVER;
                    end else begin
                        flash_count_d = flash_count_q + FC_W'(1);
                    end
                end
                ST_OVER: begin
                    if (bus.game_state_in != 3'd0) begin
                        state_d = ST_PLAY;
                    end
                end
                default: state_d = ST_PLAY;
            endcase
        end
    end

    // The frame_end pixel itself is folded into the latched total, then the accumulator restarts.
    always_comb begin
        coll_total = coll_acc_q;
        if (bus.data_valid_in && bus.is_collision_in && (coll_acc_q != COUNT_MAX)) begin
            coll_total = coll_acc_q + 20'd1;
        end
        coll_acc_d   = frame_end ? '0 : coll_total;
        coll_count_d = frame_end ? coll_total : coll_count_q;
        frame_done_d = frame_end;
    end

    // Tint is captured with the pixel so a state change at frame_end never touches that frame.
    always_comb begin
        s1_d              = '0;
        s1_d.valid        = bus.data_valid_in;
        s1_d.hcount       = bus.hcount_in;
        s1_d.vcount       = bus.vcount_in;
        s1_d.wall         = bus.is_wall_in;
        s1_d.person       = bus.is_person_in;
        s1_d.collision    = bus.is_collision_in;
        s1_d.wall_depth   = bus.wall_depth_in;
        s1_d.player_depth = bus.player_depth_in;
        s1_d.cam_rgb      = {bus.camera_pixel_in[15:11], bus.camera_pixel_in[15:13],
                             bus.camera_pixel_in[10:5],  bus.camera_pixel_in[10:9],
                             bus.camera_pixel_in[4:0],   bus.camera_pixel_in[4:2]};
        s1_d.tint         = TINT_NONE;
        if ((state_q == ST_FLASH) && flash_phase) begin
            s1_d.tint = TINT_INVERT;
        end else if (state_q == ST_OVER) begin
            s1_d.tint = TINT_OVER;
        end
`ifdef GOAL_BAR_EN
        s1_d.bar      = (bus.vcount_in < 10'd8)
                     && (bus.hcount_in < {1'b0, bus.wall_depth_in, 2'b00});
        s1_d.goal_hit = (bus.wall_depth_in >= 8'(GOAL_DEPTH - GOAL_DEPTH_DELTA))
                     && (bus.wall_depth_in <= 8'(GOAL_DEPTH + GOAL_DEPTH_DELTA));
`endif
    end

    logic [9:0]  grey_sum;
    logic [7:0]  grey;
    logic [23:0] base;
    logic [23:0] tinted;

    always_comb begin
        grey_sum = 10'(WALL_BASE) + {1'b0, s1_q.wall_depth, 1'b0};
        grey     = (grey_sum > 10'd255) ? 8'hFF : grey_sum[7:0];

        if (s1_q.collision) begin
            base = 24'hFF0000;
        end else if (s1_q.wall) begin
            base = {grey, grey, grey};
        end else if (s1_q.person) begin
            base = s1_q.cam_rgb;
        end else begin
            base = {1'b0, s1_q.cam_rgb[23:17], 1'b0, s1_q.cam_rgb[15:9], 1'b0, s1_q.cam_rgb[7:1]};
        end
`ifdef GOAL_BAR_EN
        if (s1_q.bar) begin
            base = s1_q.goal_hit ? 24'h00FF00 : 24'hFFFF00;
        end
`endif

        case (s1_q.tint)
            TINT_INVERT: tinted = ~base;
            TINT_OVER:   tinted = {8'hFF, 1'b0, base[15:9], 1'b0, base[7:1]};
            default:     tinted = base;
        endcase

        s2_d              = '0;
        s2_d.valid        = s1_q.valid;
        s2_d.hcount       = s1_q.hcount;
        s2_d.vcount       = s1_q.vcount;
        s2_d.player_depth = s1_q.player_depth;
        s2_d.pixel        = s1_q.valid ? tinted : 24'h0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_PLAY;
            flash_count_q <= '0;
            coll_acc_q    <= '0;
            coll_count_q  <= '0;
            frame_done_q  <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
        end else begin
            state_q       <= state_d;
            flash_count_q <= flash_count_d;
            coll_acc_q    <= coll_acc_d;
            coll_count_q  <= coll_count_d;
            frame_done_q  <= frame_done_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
        end
    end

    assign bus.hcount_out          = s2_q.hcount;
    assign bus.vcount_out          = s2_q.vcount;
    assign bus.data_valid_out      = s2_q.valid;
    assign bus.pixel_out           = s2_q.pixel;
    assign bus.player_depth_out    = s2_q.player_depth;
    assign bus.collision_count_out = coll_count_q;
    assign bus.frame_done_out      = frame_done_q;

endmodule

// File: tb/tb_game_pixel_compositor.sv
// Randomized bench for game_pixel_compositor against a frame-level behavioural model.
// Build with +define+GOAL_BAR_EN to also exercise the depth bar.
module tb_game_pixel_compositor;

    localparam int W         = 1280;
    localparam int H         = 720;
    localparam int FLASH_N   = 60;
    localparam int PERIOD    = 8;
    localparam int WALL_BASE = 64;
    localparam int CMAX      = (1 << 20) - 1;

    typedef struct packed {
        logic        valid;
        logic [10:0] h;
        logic [9:0]  v;
        logic [15:0] cam;
        logic        wall;
        logic        person;
        logic        coll;
        logic [7:0]  wd;
        logic [7:0]  pd;
        logic [2:0]  gs;
    } pix_t;

    typedef struct packed {
        logic        valid;
        logic [10:0] h;
        logic [9:0]  v;
        logic [7:0]  pd;
        logic [23:0] pixel;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in;

    game_pixel_compositor_if bus ();

    game_pixel_compositor dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    int          lost     = -1;   // -1 playing, 0..59 flash frame index, 60 game over
    int          coll_acc = 0;
    logic [19:0] coll_latched = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    endtask

    function automatic logic [23:0] model_pixel(input pix_t p, input int lost_frames);
        int r5, g6, b5, r, g, b, grey;
        logic [23:0] base;
        if (!p.valid) return 24'h0;
        r5 = int'(p.cam) / 2048;
        g6 = (int'(p.cam) / 32) % 64;
        b5 = int'(p.cam) % 32;
        r  = r5 * 8 + r5 / 4;
        g  = g6 * 4 + g6 / 16;
        b  = b5 * 8 + b5 / 4;
        grey = WALL_BASE + 2 * int'(p.wd);
        if (grey > 255) grey = 255;
        if (p.coll)        base = 24'hFF0000;
        else if (p.wall)   base = {8'(grey), 8'(grey), 8'(grey)};
        else if (p.person) base = {8'(r), 8'(g), 8'(b)};
        else               base = {8'(r / 2), 8'(g / 2), 8'(b / 2)};
`ifdef GOAL_BAR_EN
        if (int'(p.v) < 8 && int'(p.h) < 4 * int'(p.wd))
            base = (p.wd >= 8'd50 && p.wd <= 8'd70) ? 24'h00FF00 : 24'hFFFF00;
`endif
        if (lost_frames < 0) return base;
        if (lost_frames < FLASH_N) return (((lost_frames / PERIOD) % 2) == 1) ? ~base : base;
        return {8'hFF, base[15:8] >> 1, base[7:0] >> 1};
    endfunction

    task automatic advance_game(input logic [2:0] gs);
        if (gs != 3'd0)        lost = -1;
        else if (lost < 0)     lost = 0;
        else if (lost < FLASH_N) lost++;
    endtask

    task automatic drive(input pix_t p);
        exp_t e;
        logic fe;
        bus.data_valid_in   = p.valid;
        bus.hcount_in       = p.h;
        bus.vcount_in       = p.v;
        bus.camera_pixel_in = p.cam;
        bus.is_wall_in      = p.wall;
        bus.is_person_in    = p.person;
        bus.is_collision_in = p.coll;
        bus.wall_depth_in   = p.wd;
        bus.player_depth_in = p.pd;
        bus.game_state_in   = p.gs;
        fe = p.valid && (int'(p.h) == W - 1) && (int'(p.v) == H - 1);
        e.valid = p.valid;
        e.h     = p.h;
        e.v     = p.v;
        e.pd    = p.pd;
        e.pixel = model_pixel(p, lost);
        exp_q.push_back(e);
        if (p.valid && p.coll && coll_acc < CMAX) coll_acc++;
        if (fe) begin
            coll_latched = 20'(coll_acc);
            coll_acc     = 0;
            advance_game(p.gs);
        end
        @(posedge clk_in);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check("pixel", 64'(bus.pixel_out), 64'(e.pixel));
            check("meta", 64'({bus.data_valid_out, bus.hcount_out, bus.vcount_out, bus.player_depth_out}),
                  64'({e.valid, e.h, e.v, e.pd}));
        end
        check("frame_done", 64'(bus.frame_done_out), 64'(fe));
        check("coll_count", 64'(bus.collision_count_out), 64'(coll_latched));
    endtask

    function automatic pix_t rand_pix(input logic [2:0] gs);
        pix_t p;
        p.valid  = ($urandom_range(0, 9) != 0);
        p.h      = 11'($urandom_range(0, W - 1));
        p.v      = 10'($urandom_range(0, H - 1));
        if (int'(p.h) == W - 1 && int'(p.v) == H - 1) p.v = 10'd0;
        p.cam    = 16'($urandom);
        p.wall   = ($urandom_range(0, 3) == 0);
        p.person = ($urandom_range(0, 3) == 0);
        p.coll   = ($urandom_range(0, 7) == 0);
        p.wd     = 8'($urandom);
        p.pd     = 8'($urandom);
        p.gs     = gs;
        return p;
    endfunction

    function automatic pix_t idle_pix(input logic [2:0] gs);
        pix_t p;
        p = rand_pix(gs);
        p.valid = 1'b0;
        return p;
    endfunction

    function automatic pix_t end_pix(input logic [2:0] gs, input logic coll);
        pix_t p;
        p = rand_pix(gs);
        p.valid = 1'b1;
        p.h     = 11'(W - 1);
        p.v     = 10'(H - 1);
        p.coll  = coll;
        return p;
    endfunction

    function automatic pix_t plain_pix(input logic [15:0] cam, input logic wall, input logic person,
                                       input logic coll, input logic [7:0] wd, input logic [2:0] gs);
        pix_t p;
        p = rand_pix(gs);
        p.valid  = 1'b1;
        p.v      = 10'd100;
        p.cam    = cam;
        p.wall   = wall;
        p.person = person;
        p.coll   = coll;
        p.wd     = wd;
        return p;
    endfunction

    // Drive one pixel, follow it with an idle cycle, then compare the emerging pixel to a constant.
    task automatic probe(input pix_t p, input string tag, input logic [23:0] want);
        drive(p);
        drive(idle_pix(p.gs));
        check(tag, 64'(bus.pixel_out), 64'(want));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel"},  64'(bus.pixel_out),           64'd0);
        check({tag, "_valid"},  64'(bus.data_valid_out),      64'd0);
        check({tag, "_hcount"}, 64'(bus.hcount_out),          64'd0);
        check({tag, "_vcount"}, 64'(bus.vcount_out),          64'd0);
        check({tag, "_pdepth"}, 64'(bus.player_depth_out),    64'd0);
        check({tag, "_count"},  64'(bus.collision_count_out), 64'd0);
        check({tag, "_done"},   64'(bus.frame_done_out),      64'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        lost         = -1;
        coll_acc     = 0;
        coll_latched = '0;
    endtask

    initial begin
        pix_t p;
        rst_in = 1'b1;
        drive_zero: begin
            bus.data_valid_in   = 1'b0;
            bus.hcount_in       = '0;
            bus.vcount_in       = '0;
            bus.camera_pixel_in = '0;
            bus.is_wall_in      = 1'b0;
            bus.is_person_in    = 1'b0;
            bus.is_collision_in = 1'b0;
            bus.wall_depth_in   = '0;
            bus.player_depth_in = '0;
            bus.game_state_in   = '0;
        end
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst_in = 1'b0;

        // Flat camera frame, no flags: half-intensity white on every valid pixel.
        for (int i = 0; i < 20; i++) begin
            p = plain_pix(16'hFFFF, 1'b0, 1'b0, 1'b0, 8'($urandom), 3'd1);
            p.v = 10'($urandom_range(0, H - 2));
            drive(p);
        end
        check("flat_7f", 64'(bus.pixel_out), 64'h7F7F7F);
        check("flat_valid", 64'(bus.data_valid_out), 64'd1);
        p = end_pix(3'd1, 1'b0);
        p.cam = 16'hFFFF; p.wall = 1'b0; p.person = 1'b0;
        drive(p);

        probe(plain_pix(16'h1234, 1'b1, 1'b0, 1'b0, 8'd20, 3'd1), "wall_d20", 24'h686868);
        probe(plain_pix(16'h1234, 1'b1, 1'b1, 1'b0, 8'd200, 3'd1), "wall_d200_sat", 24'hFFFFFF);
        drive(end_pix(3'd1, 1'b0));

        // 36 collisions mid-frame plus one on the frame_end pixel.
        for (int i = 0; i < 36; i++) begin
            p = rand_pix(3'd1);
            p.coll = 1'b0;
            repeat ($urandom_range(0, 2)) drive(p);
            p = plain_pix(16'($urandom), 1'b0, 1'b0, 1'b1, 8'($urandom), 3'd1);
            drive(p);
        end
        drive(end_pix(3'd1, 1'b1));
        check("coll_37", 64'(bus.collision_count_out), 64'd37);
        check("done_pulse_hi", 64'(bus.frame_done_out), 64'd1);
        drive(idle_pix(3'd1));
        check("done_pulse_lo", 64'(bus.frame_done_out), 64'd0);
        for (int i = 0; i < 10; i++) begin
            p = rand_pix(3'd1);
            p.coll = 1'b0;
            drive(p);
        end
        drive(end_pix(3'd1, 1'b0));
        check("coll_0", 64'(bus.collision_count_out), 64'd0);

        for (int f = 0; f < 3; f++) begin
            repeat (30) drive(rand_pix(3'($urandom_range(1, 7))));
            drive(end_pix(3'($urandom_range(1, 7)), 1'($urandom)));
        end

        // Game lost at row 300: the rest of this frame must still be composited normally.
        repeat (10) drive(rand_pix(3'd1));
        p = plain_pix(16'h0, 1'b0, 1'b0, 1'b1, 8'd0, 3'd0);
        p.v = 10'd300;
        probe(p, "no_tear", 24'hFF0000);
        repeat (10) drive(rand_pix(3'd0));
        drive(end_pix(3'd0, 1'b0));

        for (int f = 0; f < FLASH_N; f++) begin
            repeat (4) drive(rand_pix(3'd0));
            p = plain_pix(16'h0, 1'b0, 1'b0, 1'b1, 8'd0, 3'd0);
            if (f == 0)  probe(p, "flash_f0", 24'hFF0000);
            if (f == 8)  probe(p, "flash_f8_inv", 24'h00FFFF);
            if (f == 15) probe(p, "flash_f15_inv", 24'h00FFFF);
            if (f == 16) probe(p, "flash_f16", 24'hFF0000);
            drive(end_pix(3'd0, 1'b0));
        end
        probe(plain_pix(16'hFFFF, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0), "over_tint", 24'hFF7F7F);

        // Reset mid-frame while in OVER: counts and FSM clear at once.
        for (int i = 0; i < 3; i++) drive(plain_pix(16'h0, 1'b0, 1'b0, 1'b1, 8'd0, 3'd0));
        #2;
        rst_in = 1'b1;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        for (int i = 0; i < 5; i++) drive(plain_pix(16'h0, 1'b0, 1'b0, 1'b1, 8'd0, 3'd2));
        probe(plain_pix(16'hFFFF, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2), "play_after_rst", 24'hFFFFFF);
        for (int i = 0; i < 10; i++) begin
            p = rand_pix(3'd2);
            p.coll = 1'b0;
            drive(p);
        end
        drive(end_pix(3'd2, 1'b0));
        check("coll_after_rst", 64'(bus.collision_count_out), 64'd5);

        // Lose again, run out the flash, then resume play from OVER.
        drive(end_pix(3'd0, 1'b0));
        for (int f = 0; f < FLASH_N; f++) begin
            repeat (3) drive(rand_pix(3'd0));
            drive(end_pix(3'd0, 1'($urandom)));
        end
        probe(plain_pix(16'hFFFF, 1'b0, 1'b1, 1'b0, 8'd0, 3'd1), "over_holds", 24'hFF7F7F);
        repeat (5) drive(rand_pix(3'd1));
        drive(end_pix(3'd1, 1'b0));
        probe(plain_pix(16'hFFFF, 1'b0, 1'b1, 1'b0, 8'd0, 3'd1), "play_again", 24'hFFFFFF);

`ifdef GOAL_BAR_EN
        p = plain_pix(16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd55, 3'd1);
        p.v = 10'd3;
        p.h = 11'd100;
        probe(p, "bar_goal", 24'h00FF00);
        p.wd = 8'd30;
        p.h  = 11'd50;
        probe(p, "bar_far", 24'hFFFF00);
        p.h  = 11'd130;
        probe(p, "bar_off", 24'h7F7F7F);
`endif
        repeat (20) drive(rand_pix(3'd1));
        drive(end_pix(3'd1, 1'b1));
        drive(idle_pix(3'd1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
